imem_boot_loader: RTL

//  Upstream neighbour of proc_top: streams a program image into instruction memory over a byte

---
 rtl/boot_pkg.sv | 17 +
 rtl/byte_word_packer.sv | 48 ++++
 rtl/imem_boot_loader.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and word geometry for the instruction-memory boot loader.
package boot_pkg;

  localparam int BOOT_WORD_W    = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CSUM,
    RELEASE,
    RUN,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid marks the 4th handshake.
module byte_word_packer
  import boot_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   byte_ready,
  output logic                   word_valid,
  output logic [BOOT_WORD_W-1:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic             hs;

  // The last byte bypasses the holding register so the word is complete on its handshake.
  always_comb begin
    hs         = byte_valid && byte_ready;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word_valid = hs && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    word       = {byte_data, shift_q};
    if (hs) begin
      cnt_d = cnt_q + 1'b1;
      case (cnt_q)
        2'd0:    shift_d[7:0]   = byte_data;
        2'd1:    shift_d[15:8]  = byte_data;
        2'd2:    shift_d[23:16] = byte_data;
        default: shift_d        = shift_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into imem and releases the core after a clean load.
// Optional BOOT_CHECKSUM_EN adds a trailing 32-bit wrapping-sum check before release.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH  = 256,
  parameter int ADDR_W      = $clog2(IMEM_DEPTH),
  parameter int RELEASE_DLY = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic [BOOT_WORD_W-1:0] imem_wdata,
  output logic                   core_resetn,
  output logic                   boot_busy,
  output logic                   boot_done,
  output logic                   boot_err,
  output logic [ADDR_W:0]        words_loaded
);

  localparam int DLY_W = $clog2(RELEASE_DLY + 1);

  boot_state_t            state_q, state_d;
  logic [ADDR_W:0]        n_q, n_d;
  logic [ADDR_W:0]        word_cnt_q, word_cnt_d;
  logic [DLY_W-1:0]       dly_q, dly_d;
  logic                   imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]      imem_addr_q, imem_addr_d;
  logic [BOOT_WORD_W-1:0] imem_wdata_q, imem_wdata_d;
  logic                   word_valid;
  logic [BOOT_WORD_W-1:0] word;
  boot_state_t            after_load;
`ifdef BOOT_CHECKSUM_EN
  logic [BOOT_WORD_W-1:0] csum_q, csum_d;
`endif

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .byte_ready (rx_ready),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef BOOT_CHECKSUM_EN
  assign after_load = CSUM;
`else
  assign after_load = RELEASE;
`endif

  // The strobe cycle is a one-cycle bubble on the byte link.
  always_comb begin
    rx_ready     = ((state_q == LEN) || (state_q == LOAD) || (state_q == CSUM)) && !imem_we_q;
    core_resetn  = (state_q == RUN);
    boot_done    = (state_q == RUN);
    boot_err     = (state_q == ERROR);
    boot_busy    = (state_q == LEN) || (state_q == LOAD) || (state_q == CSUM) ||
                   (state_q == RELEASE);
    imem_we      = imem_we_q;
    imem_addr    = imem_addr_q;
    imem_wdata   = imem_wdata_q;
    words_loaded = word_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_cnt_d   = word_cnt_q;
    dly_d        = dly_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: state_d = LEN;
      LEN: begin
        // Length is compared at full 32-bit width so large N cannot alias to a small one.
        if (word_valid) begin
          dly_d = '0;
          if (word > BOOT_WORD_W'(IMEM_DEPTH)) begin
            state_d = ERROR;
          end else if (word == '0) begin
            state_d = after_load;
          end else begin
            n_d     = word[ADDR_W:0];
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (word_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_cnt_q[ADDR_W-1:0];
          imem_wdata_d = word;
          word_cnt_d   = word_cnt_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
          csum_d       = csum_q + word;
`endif
          if ((word_cnt_q + 1'b1) == n_q) begin
            state_d = after_load;
            dly_d   = '0;
          end
        end
      end
`ifdef BOOT_CHECKSUM_EN
      CSUM: begin
        if (word_valid) begin
          dly_d   = '0;
          state_d = (word == csum_q) ? RELEASE : ERROR;
        end
      end
`endif
      RELEASE: begin
        if (dly_q == DLY_W'(RELEASE_DLY)) state_d = RUN;
        else                              dly_d   = dly_q + 1'b1;
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      word_cnt_q   <= '0;
      dly_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_cnt_q   <= word_cnt_d;
      dly_q        <= dly_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule
